// File: rtl/data_frames_pkg.sv
// Frame definitions shared by the link payload receiver and its consumers.
package data_frames_pkg;

    localparam logic [7:0] PULSE_ID_TYPE = 8'h01;

    typedef struct packed {
        logic [7:0]  payload_type;
        logic [63:0] data;
    } payload_t;

endpackage

// File: rtl/payload_sync_fifo.sv
// Single-clock show-ahead FIFO for decoded frames; a push into a full buffer
// is accepted only when a pop frees a slot in the same cycle.
module payload_sync_fifo
    import data_frames_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = payload_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    T                mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;
    logic            push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Head is forced to zero when empty so stale storage never leaks out.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (pop_ok && !push_ok) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/pulse_id_receiver.sv
// Pulse-ID receiver: latches IDs, checks continuity, watches for silence and
// buffers settings frames. Optional statistics counters: PULSE_ID_RX_STATS_EN.
module pulse_id_receiver
    import data_frames_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1_600_000,
    parameter int BURST_WINDOW   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        link_locked_i,
    input  payload_t    payload_i,
    input  logic        payload_valid_i,
    output logic [63:0] pulse_id_o,
    output logic        pulse_id_strobe_o,
    output logic        pulse_id_valid_o,
    output logic        seq_error_o,
    output logic        lost_o,
    output payload_t    settings_o,
    output logic        settings_valid_o,
    input  logic        settings_ready_i,
    output logic        overflow_o,
    output logic [31:0] seq_err_count_o,
    output logic [31:0] stray_count_o
);

    typedef enum logic [2:0] {UNLOCKED, WAIT_ID, BURST, SYNCED, LOST} state_t;

    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WIN_W = $clog2(BURST_WINDOW + 1);

    state_t             state_q, state_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [63:0]        id_q, id_d;
    logic               strobe_q, strobe_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;
    logic               push, stray, active, id_frame, set_frame;
    logic               fifo_full, fifo_empty;

    assign id_frame  = payload_valid_i && link_locked_i && (payload_i.payload_type == PULSE_ID_TYPE);
    assign set_frame = payload_valid_i && link_locked_i && (payload_i.payload_type != PULSE_ID_TYPE);
    assign active    = (state_q == BURST) || (state_q == SYNCED);

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        win_d    = win_q;
        id_d     = id_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;
        push     = 1'b0;
        stray    = 1'b0;

        if (active && wd_q != WD_W'(TIMEOUT_CYCLES)) wd_d = wd_q + WD_W'(1);
        if (id_frame) wd_d = '0;

        // Any ID frame once locked resynchronises; only SYNCED/BURST compare.
        if (id_frame && state_q != UNLOCKED) begin
            id_d     = payload_i.data;
            strobe_d = 1'b1;
            err_d    = active && (payload_i.data != id_q + 64'd1);
            state_d  = BURST;
            win_d    = WIN_W'(1);
        end else begin
            case (state_q)
                UNLOCKED: begin
                    stray = set_frame;
                    if (link_locked_i) state_d = WAIT_ID;
                end
                BURST: begin
                    push = set_frame;
                    if (win_q >= WIN_W'(BURST_WINDOW)) state_d = SYNCED;
                    else                                win_d   = win_q + WIN_W'(1);
                    if (wd_q == WD_W'(TIMEOUT_CYCLES)) state_d = LOST;
                end
                SYNCED: begin
                    stray = set_frame;
                    if (wd_q == WD_W'(TIMEOUT_CYCLES)) state_d = LOST;
                end
                default: stray = set_frame;
            endcase
        end

        if (!link_locked_i) state_d = UNLOCKED;
    end

    assign ovf_d = ovf_q || (push && fifo_full && !(settings_ready_i && !fifo_empty));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= UNLOCKED;
            wd_q     <= '0;
            win_q    <= '0;
            id_q     <= '0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            win_q    <= win_d;
            id_q     <= id_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    payload_sync_fifo #(.DEPTH(FIFO_DEPTH), .T(payload_t)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (payload_i),
        .pop_i   (settings_ready_i),
        .data_o  (settings_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef PULSE_ID_RX_STATS_EN
    logic [31:0] seq_cnt_q, stray_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_cnt_q   <= '0;
            stray_cnt_q <= '0;
        end else begin
            if (err_d && seq_cnt_q != '1)   seq_cnt_q   <= seq_cnt_q + 32'd1;
            if (stray && stray_cnt_q != '1) stray_cnt_q <= stray_cnt_q + 32'd1;
        end
    end

    assign seq_err_count_o = seq_cnt_q;
    assign stray_count_o   = stray_cnt_q;
`else
    assign seq_err_count_o = '0;
    assign stray_count_o   = '0;
`endif

    assign pulse_id_o        = id_q;
    assign pulse_id_strobe_o = strobe_q;
    assign seq_error_o       = err_q;
    assign pulse_id_valid_o  = active;
    assign lost_o            = (state_q == LOST);
    assign settings_valid_o  = !fifo_empty;
    assign overflow_o        = ovf_q;

endmodule

// File: tb/tb_pulse_id_receiver.sv
// Directed bench for pulse_id_receiver: vector table plus multi-cycle sequences.
module tb_pulse_id_receiver;
    import data_frames_pkg::*;

    localparam int DEPTH = 16;
    localparam int TMO   = 80;
    localparam int BW    = 32;
`ifdef PULSE_ID_RX_STATS_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        link_locked = 1'b0;
    payload_t    payload = '0;
    logic        payload_valid = 1'b0;
    logic        settings_ready = 1'b0;
    logic [63:0] pulse_id;
    logic        strobe, pid_valid, seq_err, lost, set_valid, overflow;
    payload_t    settings;
    logic [31:0] seq_cnt, stray_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_id_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .BURST_WINDOW(BW)) dut (
        .clk               (clk),
        .reset             (reset),
        .link_locked_i     (link_locked),
        .payload_i         (payload),
        .payload_valid_i   (payload_valid),
        .pulse_id_o        (pulse_id),
        .pulse_id_strobe_o (strobe),
        .pulse_id_valid_o  (pid_valid),
        .seq_error_o       (seq_err),
        .lost_o            (lost),
        .settings_o        (settings),
        .settings_valid_o  (set_valid),
        .settings_ready_i  (settings_ready),
        .overflow_o        (overflow),
        .seq_err_count_o   (seq_cnt),
        .stray_count_o     (stray_cnt)
    );

    typedef struct {
        logic        rst, lk, vld;
        logic [7:0]  typ;
        logic [63:0] data;
        logic        e_st, e_err, e_pv, e_lost;
        logic [63:0] e_id;
        int          e_seq, e_stray;
    } vec_t;

    vec_t vec [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] t, input logic [63:0] d);
        payload       = '{payload_type: t, data: d};
        payload_valid = 1'b1;
        tick();
        payload_valid = 1'b0;
    endtask

    task automatic restart();
        reset = 1'b1;
        link_locked = 1'b1;
        settings_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        //         rst  lk   vld  typ    data                   st   err  pv   lost id                     seq stray
        vec[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 0, 0};
        vec[1]  = '{1'b0, 1'b0, 1'b1, 8'h22, 64'h5,                 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 0, 0};
        vec[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 0, 0};
        vec[3]  = '{1'b0, 1'b1, 1'b1, 8'h01, 64'h10,                1'b1, 1'b0, 1'b1, 1'b0, 64'h10,                0, 0};
        vec[4]  = '{1'b0, 1'b1, 1'b1, 8'h01, 64'h11,                1'b1, 1'b0, 1'b1, 1'b0, 64'h11,                0, 0};
        vec[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 64'h0,                 1'b0, 1'b0, 1'b1, 1'b0, 64'h11,                0, 0};
        vec[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 0, 0};
        vec[7]  = '{1'b0, 1'b1, 1'b1, 8'h22, 64'h7,                 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                 0, S};
        vec[8]  = '{1'b0, 1'b1, 1'b1, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, S};
        vec[9]  = '{1'b0, 1'b1, 1'b1, 8'h01, 64'h0,                 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                 0, S};
        vec[10] = '{1'b0, 1'b1, 1'b1, 8'h01, 64'h0,                 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                 S, S};
        vec[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 64'h0,                 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                 S, S};

        for (int i = 0; i < 12; i++) begin
            reset         = vec[i].rst;
            link_locked   = vec[i].lk;
            payload       = '{payload_type: vec[i].typ, data: vec[i].data};
            payload_valid = vec[i].vld;
            tick();
            payload_valid = 1'b0;
            check($sformatf("v%0d strobe", i), 64'(strobe), 64'(vec[i].e_st));
            check($sformatf("v%0d seq_err", i), 64'(seq_err), 64'(vec[i].e_err));
            check($sformatf("v%0d pid_valid", i), 64'(pid_valid), 64'(vec[i].e_pv));
            check($sformatf("v%0d lost", i), 64'(lost), 64'(vec[i].e_lost));
            check($sformatf("v%0d pulse_id", i), pulse_id, vec[i].e_id);
            check($sformatf("v%0d seq_cnt", i), 64'(seq_cnt), 64'(vec[i].e_seq));
            check($sformatf("v%0d stray_cnt", i), 64'(stray_cnt), 64'(vec[i].e_stray));
            check($sformatf("v%0d set_valid", i), 64'(set_valid), 64'h0);
            check($sformatf("v%0d overflow", i), 64'(overflow), 64'h0);
        end

        // Settings accepted on the last window cycle, stray one cycle later.
        restart();
        send(8'h01, 64'h30);
        repeat (BW - 1) tick();
        send(8'h22, 64'h201);
        check("win_last set_valid", 64'(set_valid), 64'h1);
        check("win_last stray", 64'(stray_cnt), 64'h0);
        send(8'h22, 64'h202);
        check("win_late stray", 64'(stray_cnt), 64'(S));
        check("win_late pid_valid", 64'(pid_valid), 64'h1);
        check("win_late head", settings.data, 64'h201);
        settings_ready = 1'b1;
        tick();
        settings_ready = 1'b0;
        check("win_late drained", 64'(set_valid), 64'h0);

        // Fill, push+pop on full, then push on full without pop.
        restart();
        send(8'h01, 64'h40);
        for (int k = 1; k <= DEPTH; k++) send(8'h22, 64'h100 + 64'(k));
        check("full overflow", 64'(overflow), 64'h0);
        check("full head", settings.data, 64'h101);
        settings_ready = 1'b1;
        send(8'h22, 64'h111);
        settings_ready = 1'b0;
        check("pushpop overflow", 64'(overflow), 64'h0);
        check("pushpop head", settings.data, 64'h102);
        send(8'h22, 64'h112);
        check("drop overflow", 64'(overflow), 64'h1);
        settings_ready = 1'b1;
        for (int k = 2; k <= DEPTH + 1; k++) begin
            check($sformatf("drain %0d valid", k), 64'(set_valid), 64'h1);
            check($sformatf("drain %0d data", k), settings.data, 64'h100 + 64'(k));
            tick();
        end
        settings_ready = 1'b0;
        check("drain empty", 64'(set_valid), 64'h0);
        check("drain head zero", 64'(settings), 64'h0);
        check("overflow sticky", 64'(overflow), 64'h1);

        // Watchdog expiry and recovery.
        restart();
        send(8'h01, 64'h40);
        repeat (TMO) tick();
        check("pre_timeout lost", 64'(lost), 64'h0);
        check("pre_timeout pid_valid", 64'(pid_valid), 64'h1);
        tick();
        check("timeout lost", 64'(lost), 64'h1);
        check("timeout pid_valid", 64'(pid_valid), 64'h0);
        send(8'h01, 64'h50);
        check("recover lost", 64'(lost), 64'h0);
        check("recover strobe", 64'(strobe), 64'h1);
        check("recover seq_err", 64'(seq_err), 64'h0);
        check("recover id", pulse_id, 64'h50);

        // Lock loss keeps the buffer; reset clears everything.
        restart();
        send(8'h01, 64'h60);
        send(8'h22, 64'h301);
        send(8'h22, 64'h302);
        link_locked = 1'b0;
        tick();
        check("unlock pid_valid", 64'(pid_valid), 64'h0);
        check("unlock set_valid", 64'(set_valid), 64'h1);
        check("unlock head", settings.data, 64'h301);
        send(8'h01, 64'h99);
        check("unlocked frame strobe", 64'(strobe), 64'h0);
        check("unlocked frame id", pulse_id, 64'h60);
        link_locked = 1'b1;
        tick();
        send(8'h01, 64'h61);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset id", pulse_id, 64'h0);
        check("reset strobe", 64'(strobe), 64'h0);
        check("reset pid_valid", 64'(pid_valid), 64'h0);
        check("reset set_valid", 64'(set_valid), 64'h0);
        check("reset settings", 64'(settings), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
